// File: rtl/ysyx_23060229_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU.
// One transaction at a time: request, memory handshake, response or timeout.
module ysyx_23060229_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_valid,
    output logic                ifu_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_err,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int MW   = DATA_W / 8;
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state_q, state_d;
    logic              grant_q;
    logic              last_q;
    logic [WD_W-1:0]   wd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MW-1:0]     wmask_q;

    logic              pick_lsu;
    logic              accept;
    logic              rsp;
    logic              tmo;
    logic              done;
    logic [DATA_W-1:0] rsp_data;

    // grant_q/last_q: 1 = LSU, 0 = IFU; a tie goes to whoever was not last
    assign pick_lsu = lsu_valid & (~ifu_valid | ~last_q);
    assign accept   = (state_q == IDLE) & (ifu_valid | lsu_valid) & ~rst;

    assign rsp  = (state_q == WAIT) & ~rst & mem_rsp_valid;
    assign tmo  = (state_q == WAIT) & ~rst & ~mem_rsp_valid & (wd_q == WD_LAST);
    assign done = rsp | tmo;
    assign rsp_data = (rsp & ~(grant_q & wen_q)) ? mem_rdata : '0;

    assign ifu_ready  = accept & ~pick_lsu;
    assign lsu_ready  = accept & pick_lsu;
    assign ifu_rvalid = done & ~grant_q;
    assign ifu_err    = tmo & ~grant_q;
    assign ifu_rdata  = grant_q ? '0 : rsp_data;
    assign lsu_rvalid = done & grant_q;
    assign lsu_err    = tmo & grant_q;
    assign lsu_rdata  = grant_q ? rsp_data : '0;

    assign mem_req_valid = (state_q == REQ) & ~rst;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (mem_req_ready) state_d = WAIT;
            WAIT:    if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b0;
            wd_q    <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= pick_lsu;
                last_q  <= pick_lsu;
                addr_q  <= pick_lsu ? lsu_addr : ifu_addr;
                wen_q   <= pick_lsu & lsu_wen;
                wdata_q <= pick_lsu ? lsu_wdata : '0;
                wmask_q <= pick_lsu ? lsu_wmask : '0;
            end
            if (state_q == REQ && mem_req_ready)
                wd_q <= '0;
            else if (state_q == WAIT)
                wd_q <= wd_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_ysyx_23060229_mem_arbiter.sv
// Directed and randomized transactions against a transaction-level model
// of round-robin arbitration, response latency and timeout.
module tb_ysyx_23060229_mem_arbiter;
    localparam int TO = 4;

    logic        clk = 0;
    logic        rst = 1;
    logic        ifu_valid = 0, ifu_ready, ifu_rvalid, ifu_err;
    logic [31:0] ifu_addr = 0, ifu_rdata;
    logic        lsu_valid = 0, lsu_ready, lsu_wen = 0, lsu_rvalid, lsu_err;
    logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
    logic [3:0]  lsu_wmask = 0;
    logic        mem_req_valid, mem_req_ready = 0, mem_wen, mem_rsp_valid = 0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic [3:0]  mem_wmask;

    int n_chk = 0;
    int n_fail = 0;
    bit last_lsu;

    ysyx_23060229_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ifu_ready"}, ifu_ready, 0);
        chk({tag, "_lsu_ready"}, lsu_ready, 0);
        chk({tag, "_ifu_rsp"}, {ifu_rvalid, ifu_err, ifu_rdata}, 0);
        chk({tag, "_lsu_rsp"}, {lsu_rvalid, lsu_err, lsu_rdata}, 0);
        chk({tag, "_mem_req"}, mem_req_valid, 0);
    endtask

    // rsp_dly: WAIT cycle (1-based) on which memory answers; > TO means never
    task automatic txn(input bit iv, input bit lv,
                       input logic [31:0] ia, input logic [31:0] la,
                       input bit lwen, input logic [31:0] lwd,
                       input logic [3:0] lmask, input logic [31:0] rd,
                       input int req_dly, input int rsp_dly);
        bit w;
        bit ewen;
        bit r;
        bit t;
        bit fin;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic [31:0] ed;
        logic [3:0] em;
        w = lv && (!iv || !last_lsu);
        last_lsu = w;
        ea = w ? la : ia;
        ewen = w && lwen;
        ewd = w ? lwd : 32'h0;
        em = w ? lmask : 4'h0;
        ifu_valid = iv; ifu_addr = ia;
        lsu_valid = lv; lsu_addr = la; lsu_wen = lwen;
        lsu_wdata = lwd; lsu_wmask = lmask;
        #1;
        chk("ifu_ready", ifu_ready, !w);
        chk("lsu_ready", lsu_ready, w);
        step();
        ifu_valid = 0;
        lsu_valid = 0;
        for (int i = 0; i <= req_dly; i++) begin
            mem_req_ready = (i == req_dly);
            #1;
            chk("mem_req_valid", mem_req_valid, 1);
            chk("mem_addr", mem_addr, ea);
            chk("mem_wen", mem_wen, ewen);
            chk("mem_wdata", mem_wdata, ewd);
            chk("mem_wmask", mem_wmask, em);
            step();
        end
        mem_req_ready = 0;
        fin = 0;
        for (int k = 1; !fin; k++) begin
            mem_rsp_valid = (k == rsp_dly);
            mem_rdata = rd;
            #1;
            r = (k == rsp_dly);
            t = !r && (k == TO);
            fin = r || t;
            ed = r && !ewen ? rd : 32'h0;
            chk("ifu_rvalid", ifu_rvalid, fin && !w);
            chk("ifu_err", ifu_err, t && !w);
            chk("ifu_rdata", ifu_rdata, w ? 32'h0 : ed);
            chk("lsu_rvalid", lsu_rvalid, fin && w);
            chk("lsu_err", lsu_err, t && w);
            chk("lsu_rdata", lsu_rdata, w ? ed : 32'h0);
            step();
            mem_rsp_valid = 0;
        end
    endtask

    initial begin
        step();
        step();
        chk_quiet("reset");
        chk("reset_mem_fields",
            {mem_addr, mem_wen, mem_wdata, mem_wmask}, 0);
        rst = 0;
        last_lsu = 0;

        txn(1, 0, 32'h8000_0000, 0, 0, 0, 0, 32'h0000_0413, 0, 1);

        last_lsu = 1;
        rst = 1;
        step();
        rst = 0;
        last_lsu = 0;
        for (int i = 0; i < 6; i++)
            txn(1, 1, $urandom, $urandom, 0, $urandom, 4'hF, $urandom, 0, 1);

        txn(0, 1, 0, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'hF, $urandom, 3, 1);

        txn(1, 0, $urandom, 0, 0, 0, 0, $urandom, 1, 99);
        mem_rsp_valid = 1;
        mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("late_rsp_ifu", ifu_rvalid, 0);
            chk("late_rsp_lsu", lsu_rvalid, 0);
            step();
        end
        mem_rsp_valid = 0;

        txn(0, 1, 0, $urandom, 0, 0, 0, 32'hCAFE_F00D, 0, TO);
        txn(0, 1, 0, $urandom, 0, 0, 0, $urandom, 2, 99);

        lsu_valid = 1;
        lsu_wen = 0;
        lsu_addr = 32'h8000_0200;
        #1;
        chk("rst_lsu_ready", lsu_ready, 1);
        step();
        lsu_valid = 0;
        mem_req_ready = 1;
        #1;
        chk("rst_req", mem_req_valid, 1);
        step();
        mem_req_ready = 0;
        rst = 1;
        mem_rsp_valid = 1;
        mem_rdata = 32'h5555_AAAA;
        #1;
        chk("rst_no_rvalid", lsu_rvalid, 0);
        step();
        rst = 0;
        mem_rsp_valid = 0;
        #1;
        chk_quiet("after_rst");
        chk("after_rst_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, 0);
        last_lsu = 0;
        txn(1, 1, $urandom, $urandom, 0, 0, 0, $urandom, 0, 1);

        for (int i = 0; i < 40; i++) begin
            bit iv;
            bit lv;
            iv = 1'($urandom);
            lv = 1'($urandom);
            if (!iv && !lv) lv = 1;
            txn(iv, lv, $urandom, $urandom, 1'($urandom), $urandom,
                4'($urandom), $urandom, $urandom_range(0, 3),
                $urandom_range(1, TO + 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
